// File: rtl/hpu_pkg.sv
// Shared HPU definitions: sequencer state encoding and instruction-word decode helpers.
package hpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int INST_W  = 16;
  localparam int OP_ADDR = 15;
  localparam int OP_LOAD = 14;
  localparam int OP_WB   = 10;
  localparam int OP_LAST = 10;

  function automatic logic is_wb_item(input logic [INST_W-1:0] d);
    return d[OP_ADDR] & d[OP_WB];
  endfunction

  function automatic logic is_last(input logic [INST_W-1:0] d);
    return ~d[OP_ADDR] & (d[14:11] == 4'b0000) & d[OP_LAST];
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Per-core front-end: fills item memory from the random source, then streams
// instructions to the core with get_v/exec alignment, store counting and completion.
module core_sequencer
  import hpu_pkg::*;
#(
  parameter int ITEM_NUM = 1024,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              gen_en,
  input  logic              rand_valid,
  output logic              rand_ready,
  input  logic              inst_valid,
  input  logic [15:0]       inst_data,
  output logic              inst_ready,
  input  logic              core_store,
  input  logic              core_last,
  output logic              run,
  output logic              gen,
  output logic              update_item,
  output logic [ADDR_W-1:0] item_a,
  output logic              get_v,
  output logic [15:0]       get_d,
  output logic              exec,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  store_count
);

  if ((ITEM_NUM < 1) || (ITEM_NUM > (1 << ADDR_W))) begin : g_bad_item_num
    $error("core_sequencer: ITEM_NUM out of range for ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ITEM_NUM - 1);

  seq_state_t state, state_nxt;
  logic              clr_job;
  logic              bubble_q;
  logic              exec_q;
  logic [ADDR_W-1:0] item_a_q;
  logic [CNT_W-1:0]  store_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    clr_job     = 1'b0;
    gen         = 1'b0;
    run         = 1'b0;
    update_item = 1'b0;
    inst_ready  = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          clr_job   = 1'b1;
          state_nxt = gen_en ? GEN : RUN;
        end
      end
      GEN: begin
        gen         = 1'b1;
        update_item = rand_valid;
        if (rand_valid && (item_a_q == LAST_A)) state_nxt = RUN;
      end
      RUN: begin
        run = 1'b1;
        // A word taken alongside core_last would never execute, so hold it in the FIFO.
        inst_ready = inst_valid & ~bubble_q & ~core_last;
        if (core_last)                            state_nxt = DONE;
        else if (inst_ready && is_last(inst_data)) state_nxt = DRAIN;
      end
      DRAIN: begin
        run = 1'b1;
        if (core_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rand_ready  = update_item;
  assign get_v       = inst_ready;
  assign get_d       = get_v ? inst_data : 16'h0000;
  assign exec        = exec_q;
  assign item_a      = item_a_q;
  assign store_count = store_count_q;

  // The bubble after wb.item lets the core finish its item-memory write before a later load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q        <= 1'b0;
      bubble_q      <= 1'b0;
      item_a_q      <= '0;
      store_count_q <= '0;
    end else begin
      exec_q   <= get_v;
      bubble_q <= get_v & is_wb_item(inst_data);
      if (clr_job)          item_a_q <= '0;
      else if (update_item) item_a_q <= item_a_q + ADDR_W'(1);
      if (clr_job) begin
        store_count_q <= '0;
      end else if (core_store && run && (store_count_q != {CNT_W{1'b1}})) begin
        store_count_q <= store_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed, table-driven bench for core_sequencer with ITEM_NUM=4.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, gen_en, rand_valid, inst_valid, core_store, core_last;
  logic [15:0] inst_data;
  logic        rand_ready, inst_ready, run, gen, update_item, get_v, exec, busy, done;
  logic [9:0]  item_a;
  logic [15:0] get_d, store_count;

  core_sequencer #(.ITEM_NUM(4), .ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gen_en(gen_en),
    .rand_valid(rand_valid), .rand_ready(rand_ready),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
    .core_store(core_store), .core_last(core_last),
    .run(run), .gen(gen), .update_item(update_item), .item_a(item_a),
    .get_v(get_v), .get_d(get_d), .exec(exec), .busy(busy), .done(done),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  // flags = {run, gen, update_item, rand_ready, inst_ready, get_v, exec, busy, done}
  logic [50:0] obs;
  assign obs = {run, gen, update_item, rand_ready, inst_ready, get_v, exec, busy, done,
                get_d, item_a, store_count};

  typedef struct {
    logic        st, ge, rv, iv;
    logic [15:0] d;
    logic        cs, cl;
    logic [8:0]  f;
    logic [15:0] gd;
    logic [9:0]  ia;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(input logic st, input logic ge, input logic rv, input logic iv,
                              input logic [15:0] d, input logic cs, input logic cl,
                              input logic [8:0] f, input logic [15:0] gd,
                              input logic [9:0] ia, input logic [15:0] cnt);
    vec_t v;
    v.st = st; v.ge = ge; v.rv = rv; v.iv = iv; v.d = d; v.cs = cs; v.cl = cl;
    v.f = f; v.gd = gd; v.ia = ia; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [50:0] got, input logic [50:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      passed++;
  endtask

  task automatic idle_inputs();
    start = 0; gen_en = 0; rand_valid = 0; inst_valid = 0; inst_data = 16'h0;
    core_store = 0; core_last = 0;
  endtask

  localparam logic [8:0] F_IDLE = 9'b000000000;
  localparam logic [8:0] F_GENU = 9'b011100010;
  localparam logic [8:0] F_GEN0 = 9'b010000010;
  localparam logic [8:0] F_ISS0 = 9'b100011010;
  localparam logic [8:0] F_ISS1 = 9'b100011110;
  localparam logic [8:0] F_RUX1 = 9'b100000110;
  localparam logic [8:0] F_RUX0 = 9'b100000010;
  localparam logic [8:0] F_DONE = 9'b000000011;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle_inputs();

    // GEN with rand_valid every cycle, then stream load/store/last
    vecs.push_back(mk(1,1,0,0,16'h0000,0,0, F_IDLE,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd1,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd2,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd3,16'd0));
    vecs.push_back(mk(0,0,1,1,16'hC005,0,0, F_ISS0,16'hC005,10'd4,16'd0));
    vecs.push_back(mk(0,0,1,1,16'h0800,0,0, F_ISS1,16'h0800,10'd4,16'd0));
    vecs.push_back(mk(0,0,0,1,16'h0400,1,0, F_ISS1,16'h0400,10'd4,16'd0));
    vecs.push_back(mk(0,0,0,1,16'h1234,0,0, F_RUX1,16'h0000,10'd4,16'd1));
    vecs.push_back(mk(0,0,0,1,16'h1234,0,1, F_RUX0,16'h0000,10'd4,16'd1));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_DONE,16'h0000,10'd4,16'd1));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_IDLE,16'h0000,10'd4,16'd1));
    // RUN only: wb.item bubble, FIFO gap, last
    vecs.push_back(mk(1,0,0,1,16'h8403,0,0, F_IDLE,16'h0000,10'd4,16'd1));
    vecs.push_back(mk(0,0,0,1,16'h8403,0,0, F_ISS0,16'h8403,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,1,16'hC003,0,0, F_RUX1,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,1,16'hC003,0,0, F_ISS0,16'hC003,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_RUX1,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,1,16'h0801,0,0, F_ISS0,16'h0801,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,1,16'h0400,1,0, F_ISS1,16'h0400,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,0, F_RUX1,16'h0000,10'd0,16'd1));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,1, F_RUX0,16'h0000,10'd0,16'd2));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_DONE,16'h0000,10'd0,16'd2));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_IDLE,16'h0000,10'd0,16'd2));
    // GEN with stalls, start while busy ignored, core_last during RUN completes
    vecs.push_back(mk(1,1,0,0,16'h0000,0,0, F_IDLE,16'h0000,10'd0,16'd2));
    vecs.push_back(mk(1,0,0,0,16'h0000,0,0, F_GEN0,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd0,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_GEN0,16'h0000,10'd1,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd1,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_GEN0,16'h0000,10'd2,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd2,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_GEN0,16'h0000,10'd3,16'd0));
    vecs.push_back(mk(0,0,1,0,16'h0000,0,0, F_GENU,16'h0000,10'd3,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,1,1, F_RUX0,16'h0000,10'd4,16'd0));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_DONE,16'h0000,10'd4,16'd1));
    vecs.push_back(mk(0,0,0,0,16'h0000,0,0, F_IDLE,16'h0000,10'd4,16'd1));

    repeat (2) @(negedge clk);
    #1 check("reset_state", obs, 51'd0);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].st; gen_en = vecs[i].ge; rand_valid = vecs[i].rv;
      inst_valid = vecs[i].iv; inst_data = vecs[i].d;
      core_store = vecs[i].cs; core_last = vecs[i].cl;
      #1 check($sformatf("vec%0d", i), obs,
               {vecs[i].f, vecs[i].gd, vecs[i].ia, vecs[i].cnt});
    end

    // async reset in the middle of RUN, then a clean restart
    @(negedge clk); idle_inputs(); start = 1;
    @(negedge clk); start = 0; inst_valid = 1; inst_data = 16'hC005;
    #1 check("prerst_issue", {50'd0, get_v}, 51'd1);
    #2 rst_n = 0;
    #1 check("rst_async_outputs", obs, 51'd0);
    @(negedge clk); idle_inputs(); rst_n = 1;
    #1 check("rst_release_idle", obs, 51'd0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; inst_valid = 1; inst_data = 16'h0400;
    #1 check("restart_issue_last", obs, {F_ISS0, 16'h0400, 10'd0, 16'd0});
    @(negedge clk); inst_valid = 1; inst_data = 16'hC001; core_last = 1;
    #1 check("restart_drain", obs, {F_RUX1, 16'h0000, 10'd0, 16'd0});
    @(negedge clk); idle_inputs();
    #1 check("restart_done", obs, {F_DONE, 16'h0000, 10'd0, 16'd0});
    @(negedge clk);
    #1 check("restart_idle", obs, 51'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
